rf_wb_arbiter: RTL and testbench

Write-side controller for the single register-file write port (WE/A3/WD).
- Merges in-order pipeline writebacks with results from long-latency units (divider, load miss path).
- Long-latency results are buffered in a small queue and drained into idle write-port cycles.
- Keeps a per-register pending scoreboard so decode can stall on registers whose long-latency result has not been written yet.

---
 rtl/rv_pkg.sv | 14 +
 rtl/wb_fifo.sv | 68 ++++++
 rtl/rf_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file writeback constants and the queued result record.
// Used by the writeback arbiter and its result queue.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the write
// port is free. Head is visible on rdata whenever the FIFO is not empty.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline writebacks with queued
// long-latency results and tracks which registers still await a result.
module rf_wb_arbiter
  import rv_pkg::REG_AW;
#(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_wd,
  output logic              pipe_stall,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [REG_AW-1:0] mc_rd,
  input  logic [XLEN-1:0]   mc_wd,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] chk_a1,
  input  logic [REG_AW-1:0] chk_a2,
  input  logic [REG_AW-1:0] chk_ad,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              chk_busyd,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_a3,
  output logic [XLEN-1:0]   rf_wd,
  output logic [CW-1:0]     q_count
);

  localparam int EW = REG_AW + XLEN;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [EW-1:0]     head;
  logic              q_full;
  logic              q_empty;
  logic              head_valid;
  logic [REG_AW-1:0] head_rd;
  logic [XLEN-1:0]   head_wd;
  logic              pipe_eff;
  logic              force_pop;
  logic              pop;
  logic              push;

  logic [SW-1:0]     starve_q, starve_d;
  logic [NREG-1:0]   pend_q, pend_d;

  assign head_valid = !q_empty;
  assign head_rd    = head[EW-1 -: REG_AW];
  assign head_wd    = head[XLEN-1:0];
  assign mc_ready   = !q_full;
  assign push       = mc_valid && mc_ready;
  assign pipe_eff   = pipe_we && (pipe_rd != '0) && !reset;
  assign force_pop  = head_valid && (starve_q == SW'(STARVE_LIMIT));
  assign pop        = head_valid && (force_pop || !pipe_eff);
  assign pipe_stall = force_pop;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({mc_rd, mc_wd}),
    .pop   (pop),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    if (pop) begin
      rf_we = (head_rd != '0);
      rf_a3 = head_rd;
      rf_wd = head_wd;
    end else if (pipe_eff) begin
      rf_we = 1'b1;
      rf_a3 = pipe_rd;
      rf_wd = pipe_wd;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!head_valid || pop) begin
      starve_d = '0;
    end else if (pipe_eff && starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle re-issue stays pending.
  always_comb begin
    pend_d = pend_q;
    if (pop && head_rd != '0) begin
      pend_d[head_rd] = 1'b0;
    end
    if (issue_valid && issue_rd != '0) begin
      pend_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      pend_q   <= '0;
    end else begin
      starve_q <= starve_d;
      pend_q   <= pend_d;
    end
  end

  assign chk_busy1 = pend_q[chk_a1] &&
                     !(pop && head_rd == chk_a1 && chk_a1 != '0);
  assign chk_busy2 = pend_q[chk_a2] &&
                     !(pop && head_rd == chk_a2 && chk_a2 != '0);
  assign chk_busyd = pend_q[chk_ad] &&
                     !(pop && head_rd == chk_ad && chk_ad != '0);

  a_issue_pending: assert property (@(posedge clk) disable iff (reset)
    !(issue_valid && issue_rd != '0 && pend_q[issue_rd] &&
      !(pop && head_rd == issue_rd)));

  a_pipe_pending: assert property (@(posedge clk) disable iff (reset)
    !(pipe_eff && pend_q[pipe_rd] && !(pop && head_rd == pipe_rd)));

  a_pop_unpending: assert property (@(posedge clk) disable iff (reset)
    !(pop && head_rd != '0 && !pend_q[head_rd]));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a queue-based expectation model.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_rf_wb_arbiter;

  localparam int QD = 4;
  localparam int SL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        pipe_stall;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_wd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_a1, chk_a2, chk_ad;
  logic        chk_busy1, chk_busy2, chk_busyd;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [2:0]  q_count;

  int checks = 0;
  int errors = 0;

  logic [36:0] sbq[$];
  logic [31:0] pend;
  int          st;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_we     (pipe_we),
    .pipe_rd     (pipe_rd),
    .pipe_wd     (pipe_wd),
    .pipe_stall  (pipe_stall),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_rd       (mc_rd),
    .mc_wd       (mc_wd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_a1      (chk_a1),
    .chk_a2      (chk_a2),
    .chk_ad      (chk_ad),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2),
    .chk_busyd   (chk_busyd),
    .rf_we       (rf_we),
    .rf_a3       (rf_a3),
    .rf_wd       (rf_wd),
    .q_count     (q_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    pipe_we     = 1'b0;
    pipe_rd     = '0;
    pipe_wd     = '0;
    mc_valid    = 1'b0;
    mc_rd       = '0;
    mc_wd       = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] wd);
    pipe_we = 1'b1;
    pipe_rd = rd;
    pipe_wd = wd;
  endtask

  task automatic mc(input logic [4:0] rd, input logic [31:0] wd);
    mc_valid = 1'b1;
    mc_rd    = rd;
    mc_wd    = wd;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
  endtask

  function automatic logic exp_busy(input logic [4:0] a, input logic pop,
                                    input logic [4:0] hrd);
    return pend[a] && !(pop && hrd == a && a != 5'd0);
  endfunction

  task automatic step();
    logic        head, frc, peff, pop, full_m;
    logic [36:0] e;
    logic [4:0]  hrd;
    @(negedge clk);
    head   = sbq.size() != 0;
    full_m = sbq.size() == QD;
    frc    = head && st == SL;
    peff   = pipe_we && pipe_rd != 5'd0;
    pop    = head && (frc || !peff);
    e      = head ? sbq[0] : '0;
    hrd    = e[36:32];
    if (pop) begin
      chk("drain_we", 64'(rf_we), 64'(hrd != 5'd0));
      chk("drain_a3", 64'(rf_a3), 64'(hrd));
      chk("drain_wd", 64'(rf_wd), 64'(e[31:0]));
    end else if (peff) begin
      chk("pipe_we", 64'(rf_we), 64'd1);
      chk("pipe_a3", 64'(rf_a3), 64'(pipe_rd));
      chk("pipe_wd", 64'(rf_wd), 64'(pipe_wd));
    end else begin
      chk("idle_we", 64'(rf_we), 64'd0);
    end
    chk("stall", 64'(pipe_stall), 64'(frc));
    chk("ready", 64'(mc_ready), 64'(!full_m));
    chk("qcount", 64'(q_count), 64'(sbq.size()));
    chk("busy1", 64'(chk_busy1), 64'(exp_busy(chk_a1, pop, hrd)));
    chk("busy2", 64'(chk_busy2), 64'(exp_busy(chk_a2, pop, hrd)));
    chk("busyd", 64'(chk_busyd), 64'(exp_busy(chk_ad, pop, hrd)));
    @(posedge clk);
    if (pop) begin
      void'(sbq.pop_front());
      if (hrd != 5'd0) pend[hrd] = 1'b0;
    end
    if (mc_valid && !full_m) sbq.push_back({mc_rd, mc_wd});
    if (issue_valid && issue_rd != 5'd0) pend[issue_rd] = 1'b1;
    if (!head || pop) st = 0;
    else if (peff && st < SL) st++;
    #1;
  endtask

  initial begin
    clr();
    chk_a1 = '0;
    chk_a2 = '0;
    chk_ad = '0;
    pend   = '0;
    st     = 0;
    reset  = 1'b1;
    pipe(5'd9, 32'h99);
    @(negedge clk);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_a3", 64'(rf_a3), 64'd0);
    chk("rst_wd", 64'(rf_wd), 64'd0);
    chk("rst_stall", 64'(pipe_stall), 64'd0);
    chk("rst_ready", 64'(mc_ready), 64'd1);
    chk("rst_qcount", 64'(q_count), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clr();

    // idle drain of a single long-latency result
    chk_a1 = 5'd5;
    issue(5'd5);
    step();
    clr();
    step();
    step();
    mc(5'd5, 32'hDEADBEEF);
    step();
    clr();
    step();
    step();

    // pipeline priority, then starvation forcing the head through
    chk_a1 = 5'd3;
    issue(5'd3);
    step();
    clr();
    mc(5'd3, 32'h33);
    pipe(5'd9, 32'h11);
    step();
    mc_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pipe(5'd9, 32'h11 + 32'(i));
      step();
    end
    clr();

    // fill the queue under continuous pipeline traffic
    chk_a1 = 5'd10;
    chk_a2 = 5'd13;
    chk_ad = 5'd14;
    for (int i = 0; i < 5; i++) begin
      issue(5'(10 + i));
      step();
    end
    clr();
    for (int i = 0; i < 5; i++) begin
      pipe(5'd9, 32'h100 + 32'(i));
      mc(5'(10 + i), 32'hA0 + 32'(i));
      step();
    end
    clr();
    for (int i = 0; i < 5; i++) step();

    // x0 handling
    chk_a1 = 5'd6;
    chk_a2 = 5'd20;
    chk_ad = 5'd0;
    issue(5'd20);
    step();
    issue(5'd6);
    step();
    clr();
    mc(5'd6, 32'h66);
    pipe(5'd9, 32'h77);
    step();
    clr();
    pipe(5'd0, 32'h88);
    step();
    clr();
    mc(5'd0, 32'h55);
    step();
    clr();
    step();
    step();

    // asynchronous reset with two queued entries
    chk_a1 = 5'd5;
    chk_a2 = 5'd7;
    issue(5'd5);
    step();
    issue(5'd7);
    step();
    clr();
    pipe(5'd9, 32'h1);
    mc(5'd5, 32'h5);
    step();
    mc(5'd7, 32'h7);
    step();
    mc_valid = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_qcount", 64'(q_count), 64'd0);
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_busy5", 64'(chk_busy1), 64'd0);
    chk("mid_rst_busy7", 64'(chk_busy2), 64'd0);
    chk("mid_rst_ready", 64'(mc_ready), 64'd1);
    sbq.delete();
    pend = '0;
    st   = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clr();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
